alu_arb: RTL and testbench
==========================

ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 SHALL provide parameter EXEC_CYCLES, default 1, ALU settle cycles per operation (legal 1..15).
REQ-002 SHALL provide port clk  input  1  sole clock, rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide ports req0_valid/req1_valid  input  1  requester command valid.
REQ-005 SHALL provide ports req0_ready/req1_ready  output  1  command accepted this cycle.
REQ-006 SHALL provide ports req0_a, req0_b, req1_a, req1_b  input  8  operands.
REQ-007 SHALL provide ports req0_op/req1_op  input  2  ALU opcode, passed through unmodified.
REQ-008 SHALL provide ports alu_a, alu_b  output  8 and alu_op  output  2  registered drive to the shared ALU.
REQ-009 SHALL provide ports alu_y  input  8, and alu_overflow, alu_parity, alu_greater, alu_is_eq, alu_less  input  1  ALU results.
REQ-010 SHALL provide ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1 (winning requester), rsp_y  output  8, rsp_flags  output  5 {overflow,parity,greater,is_eq,less}.

Function
REQ-011 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-012 In IDLE, SHALL grant one valid requester; if both are valid, SHALL grant the requester not granted last (round-robin).
REQ-013 SHALL assert reqN_ready combinationally only in IDLE and only for the granted requester; accept = reqN_valid & reqN_ready.
REQ-014 On accept, SHALL latch a/b/op into alu_a/alu_b/alu_op, latch rsp_id, update last-grant, load the exec counter with EXEC_CYCLES, and enter EXEC.
REQ-015 In EXEC, SHALL decrement the counter each cycle; when the counter is 1, SHALL sample alu_y and the flags into the rsp registers and enter RESP.
REQ-016 Latency: accept at cycle T -> rsp_valid high from cycle T+EXEC_CYCLES+1.
REQ-017 In RESP, SHALL hold rsp_valid and all rsp_* stable until rsp_ready; on rsp_valid & rsp_ready, SHALL deassert rsp_valid and enter IDLE.
REQ-018 SHALL allow a new accept no earlier than the cycle after the response handshake; no bypass and no queueing.
REQ-019 alu_a/alu_b/alu_op SHALL hold their last value outside EXEC.
REQ-020 reqN_valid deasserting before accept SHALL have no effect; input changes after accept SHALL be ignored.
REQ-021 rsp_ready high outside RESP SHALL be ignored.

Reset
REQ-022 While rst_n=0 at a clk edge, SHALL enter IDLE, clear rsp_valid, rsp_id, rsp_y, rsp_flags, alu_a, alu_b, alu_op and the counter to 0, and set last-grant to 1 so that req0 wins the first tie.
REQ-023 Reset asserted in EXEC or RESP SHALL abort the operation without issuing a response.
REQ-024 While rst_n=0, req0_ready and req1_ready SHALL be 0.

Configuration
REQ-025 Macro ALU_ARB_FLAGS_EN defined: rsp_flags SHALL carry the sampled ALU flags per REQ-015.
REQ-026 Macro ALU_ARB_FLAGS_EN undefined: rsp_flags SHALL be constant 5'b0, flag inputs SHALL be unused, and no flag registers SHALL be built; all other behaviour is identical.

Verification
REQ-027 EXEC_CYCLES=1; req0 a=8'h05 b=8'h03 op=2'b00 at T; stub alu_y=8'h08 -> alu_a=8'h05 at T+1, rsp_valid at T+2, rsp_id=0, rsp_y=8'h08.
REQ-028 Both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; the first grant after reset goes to req0.
REQ-029 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_y stable, both reqN_ready=0, no new grant.
REQ-030 EXEC_CYCLES=4; stub changes alu_y from 8'hAA to 8'h55 on the 3rd EXEC cycle -> rsp_y=8'h55, rsp_valid at T+5.
REQ-031 rst_n pulsed low in EXEC -> next cycle IDLE, rsp_valid=0, alu_a=0; no response is ever issued for the aborted command.
REQ-032 ALU_ARB_FLAGS_EN defined, stub flags=5'b10110 -> rsp_flags=5'b10110; undefined -> rsp_flags=5'b00000.

Source files
------------

// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - round-robin arbiter sharing one ALU between two requesters
// Optional response flags are built only when ALU_ARB_FLAGS_EN is defined.
module alu_arb #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [1:0] req0_op,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [1:0] req1_op,

    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_y,
    input  logic       alu_overflow,
    input  logic       alu_parity,
    input  logic       alu_greater,
    input  logic       alu_is_eq,
    input  logic       alu_less,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_y,
    output logic [4:0] rsp_flags
);

    localparam logic [3:0] LP_EXEC_CNT = EXEC_CYCLES[3:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic       r_last;
    logic [3:0] r_cnt;
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [1:0] r_alu_op;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [7:0] r_rsp_y;

    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_acc0;
    logic       w_acc1;
    logic       w_accept;
    logic       w_exec_done;

    // r_last is the requester granted most recently; a tie goes to the other one.
    assign w_gnt0 = req0_valid & (~req1_valid | r_last);
    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last);

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && (r_state == S_IDLE)) begin
            req0_ready = w_gnt0;
            req1_ready = w_gnt1;
        end
    end

    assign w_acc0      = req0_valid & req0_ready;
    assign w_acc1      = req1_valid & req1_ready;
    assign w_accept    = w_acc0 | w_acc1;
    assign w_exec_done = (r_state == S_EXEC) && (r_cnt <= 4'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept)    w_next = S_EXEC;
            S_EXEC: if (w_exec_done) w_next = S_RESP;
            S_RESP: if (rsp_ready)   w_next = S_IDLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last      <= 1'b1;
            r_cnt       <= 4'd0;
            r_alu_a     <= 8'd0;
            r_alu_b     <= 8'd0;
            r_alu_op    <= 2'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_y     <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_alu_a  <= w_acc1 ? req1_a  : req0_a;
                        r_alu_b  <= w_acc1 ? req1_b  : req0_b;
                        r_alu_op <= w_acc1 ? req1_op : req0_op;
                        r_rsp_id <= w_acc1;
                        r_last   <= w_acc1;
                        r_cnt    <= LP_EXEC_CNT;
                    end
                end
                S_EXEC: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_exec_done) begin
                        r_rsp_y     <= alu_y;
                        r_rsp_valid <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    logic [4:0] r_rsp_flags;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_flags <= 5'd0;
        end else if (w_exec_done) begin
            r_rsp_flags <= {alu_overflow, alu_parity, alu_greater, alu_is_eq, alu_less};
        end
    end

    assign rsp_flags = r_rsp_flags;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^{alu_overflow, alu_parity, alu_greater, alu_is_eq, alu_less};
    assign rsp_flags      = 5'b00000;
`endif

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_y     = r_rsp_y;

endmodule

// File: tb/tb_alu_arb.sv
// tb/tb_alu_arb.sv - self-checking bench for alu_arb with EXEC_CYCLES=1 and EXEC_CYCLES=4 instances
module tb_alu_arb;

    localparam int EC1 = 1;
    localparam int EC4 = 4;
`ifdef ALU_ARB_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: EXEC_CYCLES=1, driven by a behavioural ALU stub
    logic       a_v0, a_v1, a_rdy0, a_rdy1;
    logic [7:0] a_a0, a_b0, a_a1, a_b1;
    logic [1:0] a_op0, a_op1;
    logic [7:0] a_alu_a, a_alu_b, a_alu_y;
    logic [1:0] a_alu_op;
    logic [4:0] a_fl_in;
    logic       a_rv, a_rr, a_rid;
    logic [7:0] a_ry;
    logic [4:0] a_rf;

    // Instance B: EXEC_CYCLES=4, ALU result driven directly by the bench
    logic       b_v0, b_v1, b_rdy0, b_rdy1;
    logic [7:0] b_a0, b_b0, b_a1, b_b1;
    logic [1:0] b_op0, b_op1;
    logic [7:0] b_alu_a, b_alu_b, b_alu_y;
    logic [1:0] b_alu_op;
    logic [4:0] b_fl_in;
    logic       b_rv, b_rr, b_rid;
    logic [7:0] b_ry;
    logic [4:0] b_rf;

    // Reference ALU: {overflow,parity,greater,is_eq,less, y}
    function automatic logic [12:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        logic [8:0] w;
        case (op)
            2'd0:    w = {1'b0, a} + {1'b0, b};
            2'd1:    w = {1'b0, a} - {1'b0, b};
            2'd2:    w = {1'b0, a & b};
            default: w = {1'b0, a ^ b};
        endcase
        return {w[8], ^w[7:0], a > b, a == b, a < b, w[7:0]};
    endfunction

    always_comb {a_fl_in, a_alu_y} = alu_model(a_alu_a, a_alu_b, a_alu_op);

    alu_arb #(.EXEC_CYCLES(EC1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(a_v0), .req0_ready(a_rdy0), .req0_a(a_a0), .req0_b(a_b0), .req0_op(a_op0),
        .req1_valid(a_v1), .req1_ready(a_rdy1), .req1_a(a_a1), .req1_b(a_b1), .req1_op(a_op1),
        .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_op(a_alu_op), .alu_y(a_alu_y),
        .alu_overflow(a_fl_in[4]), .alu_parity(a_fl_in[3]), .alu_greater(a_fl_in[2]),
        .alu_is_eq(a_fl_in[1]), .alu_less(a_fl_in[0]),
        .rsp_valid(a_rv), .rsp_ready(a_rr), .rsp_id(a_rid), .rsp_y(a_ry), .rsp_flags(a_rf)
    );

    alu_arb #(.EXEC_CYCLES(EC4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_v0), .req0_ready(b_rdy0), .req0_a(b_a0), .req0_b(b_b0), .req0_op(b_op0),
        .req1_valid(b_v1), .req1_ready(b_rdy1), .req1_a(b_a1), .req1_b(b_b1), .req1_op(b_op1),
        .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_op(b_alu_op), .alu_y(b_alu_y),
        .alu_overflow(b_fl_in[4]), .alu_parity(b_fl_in[3]), .alu_greater(b_fl_in[2]),
        .alu_is_eq(b_fl_in[1]), .alu_less(b_fl_in[0]),
        .rsp_valid(b_rv), .rsp_ready(b_rr), .rsp_id(b_rid), .rsp_y(b_ry), .rsp_flags(b_rf)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_v0 = 0; a_v1 = 0; a_rr = 0;
        b_v0 = 0; b_v1 = 0; b_rr = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_v0 = 1; a_v1 = 1; a_rr = 1;
        b_v0 = 1; b_v1 = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if ({a_rdy0, a_rdy1, b_rdy0, b_rdy1} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b expected 0000", {a_rdy0, a_rdy1, b_rdy0, b_rdy1});
        end
        n_checks++;
        if ({a_rv, a_rid, a_ry, a_rf} !== 15'd0) begin
            n_fail++; $display("FAIL reset_rsp: got v=%b id=%b y=%h f=%b expected all zero", a_rv, a_rid, a_ry, a_rf);
        end
        n_checks++;
        if ({a_alu_a, a_alu_b, a_alu_op, b_alu_a, b_rv} !== 27'd0) begin
            n_fail++; $display("FAIL reset_alu: got a=%h b=%h op=%b b.a=%h b.v=%b expected zero",
                               a_alu_a, a_alu_b, a_alu_op, b_alu_a, b_rv);
        end
        a_v0 = 0; a_v1 = 0; a_rr = 0;
        b_v0 = 0; b_v1 = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [12:0] exp;
        exp = alu_model(8'h05, 8'h03, 2'b00);
        @(negedge clk);
        a_v0 = 1; a_a0 = 8'h05; a_b0 = 8'h03; a_op0 = 2'b00;
        #1;
        n_checks++;
        if ({a_rdy0, a_rdy1} !== 2'b10) begin
            n_fail++; $display("FAIL basic_grant: got %b%b expected 10", a_rdy0, a_rdy1);
        end
        @(negedge clk);
        a_v0 = 0; a_a0 = 8'hFF; a_b0 = 8'hEE;
        n_checks++;
        if (a_alu_a !== 8'h05 || a_alu_b !== 8'h03 || a_rv !== 1'b0) begin
            n_fail++; $display("FAIL basic_t1: got alu_a=%h alu_b=%h rv=%b expected 05 03 0", a_alu_a, a_alu_b, a_rv);
        end
        @(negedge clk);
        n_checks++;
        if (a_rv !== 1'b1 || a_rid !== 1'b0 || a_ry !== 8'h08) begin
            n_fail++; $display("FAIL basic_t2: got rv=%b id=%b y=%h expected 1 0 08", a_rv, a_rid, a_ry);
        end
        n_checks++;
        if (a_rf !== (FLAGS_ON ? exp[12:8] : 5'b00000)) begin
            n_fail++; $display("FAIL basic_flags: got %b expected %b", a_rf, FLAGS_ON ? exp[12:8] : 5'b00000);
        end
        a_rr = 1;
        @(negedge clk);
        a_rr = 0;
        n_checks++;
        if (a_rv !== 1'b0 || a_alu_a !== 8'h05) begin
            n_fail++; $display("FAIL basic_done: got rv=%b alu_a=%h expected 0 05", a_rv, a_alu_a);
        end
    endtask

    // Cycle model: at most one command outstanding, response due EC1+1 cycles after accept.
    task automatic run_traffic(input int n_rsp, input bit saturate);
        bit          busy = 0;
        bit          last = 1;
        int          cyc = 0;
        int          acc_cyc = 0;
        int          got = 0;
        bit          e0, e1, erv, eid;
        logic [12:0] exp = '0;
        logic [4:0]  ef;
        while (got < n_rsp && cyc < 3000) begin
            @(negedge clk);
            a_v0  = saturate ? 1'b1 : 1'($urandom_range(0, 1));
            a_v1  = saturate ? 1'b1 : 1'($urandom_range(0, 1));
            a_a0  = 8'($urandom); a_b0 = 8'($urandom); a_op0 = 2'($urandom);
            a_a1  = 8'($urandom); a_b1 = 8'($urandom); a_op1 = 2'($urandom);
            a_rr  = saturate ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            e0  = !busy && a_v0 && (!a_v1 || last);
            e1  = !busy && a_v1 && (!a_v0 || !last);
            erv = busy && (cyc >= acc_cyc + EC1 + 1);
            n_checks++;
            if (a_rdy0 !== e0 || a_rdy1 !== e1) begin
                n_fail++; $display("FAIL traffic_ready cyc %0d: got %b%b expected %b%b", cyc, a_rdy0, a_rdy1, e0, e1);
            end
            n_checks++;
            if (a_rv !== erv) begin
                n_fail++; $display("FAIL traffic_valid cyc %0d: got %b expected %b", cyc, a_rv, erv);
            end
            if (erv) begin
                ef = FLAGS_ON ? exp[12:8] : 5'b00000;
                n_checks++;
                if (a_rid !== eid || a_ry !== exp[7:0] || a_rf !== ef) begin
                    n_fail++; $display("FAIL traffic_rsp cyc %0d: got id=%b y=%h f=%b expected %b %h %b",
                                       cyc, a_rid, a_ry, a_rf, eid, exp[7:0], ef);
                end
                if (saturate) begin
                    n_checks++;
                    if (a_rid !== 1'(got % 2)) begin
                        n_fail++; $display("FAIL rr_order rsp %0d: got id=%b expected %0d", got, a_rid, got % 2);
                    end
                end
            end
            if (e0 || e1) begin
                busy    = 1;
                acc_cyc = cyc;
                eid     = e1;
                last    = e1;
                exp     = e1 ? alu_model(a_a1, a_b1, a_op1) : alu_model(a_a0, a_b0, a_op0);
            end else if (erv && a_rr) begin
                busy = 0;
                got++;
            end
            cyc++;
        end
        n_checks++;
        if (got < n_rsp) begin
            n_fail++; $display("FAIL traffic_timeout: got %0d responses expected %0d", got, n_rsp);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        run_traffic(8, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        run_traffic(40, 1'b0);
    endtask

    task automatic test_exec4_hold();
        logic [4:0] ef;
        ef = FLAGS_ON ? 5'b10110 : 5'b00000;
        do_reset();
        b_alu_y = 8'hAA; b_fl_in = 5'b10110;
        @(negedge clk);
        b_v0 = 1; b_a0 = 8'h12; b_b0 = 8'h34; b_op0 = 2'b01;
        #1;
        n_checks++;
        if (b_rdy0 !== 1'b1) begin
            n_fail++; $display("FAIL exec4_grant: got %b expected 1", b_rdy0);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            b_v0 = 1; b_v1 = 1;
            #1;
            n_checks++;
            if (b_rv !== (k == 5) || b_rdy0 !== 1'b0 || b_rdy1 !== 1'b0) begin
                n_fail++; $display("FAIL exec4_cycle %0d: got rv=%b rdy=%b%b expected rv=%b rdy=00",
                                   k, b_rv, b_rdy0, b_rdy1, k == 5);
            end
            if (k == 3) b_alu_y = 8'h55;
        end
        n_checks++;
        if (b_ry !== 8'h55 || b_rid !== 1'b0 || b_rf !== ef || b_alu_a !== 8'h12) begin
            n_fail++; $display("FAIL exec4_rsp: got y=%h id=%b f=%b alu_a=%h expected 55 0 %b 12",
                               b_ry, b_rid, b_rf, b_alu_a, ef);
        end
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            b_alu_y = 8'($urandom); b_fl_in = 5'($urandom);
            #1;
            n_checks++;
            if (b_rv !== 1'b1 || b_ry !== 8'h55 || b_rf !== ef || {b_rdy0, b_rdy1} !== 2'b00) begin
                n_fail++; $display("FAIL hold_%0d: got rv=%b y=%h f=%b rdy=%b%b expected 1 55 %b 00",
                                   j, b_rv, b_ry, b_rf, b_rdy0, b_rdy1, ef);
            end
            if (j == 5) b_rr = 1;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (b_rv !== 1'b0 || {b_rdy0, b_rdy1} !== 2'b01) begin
            n_fail++; $display("FAIL hold_release: got rv=%b rdy=%b%b expected 0 01", b_rv, b_rdy0, b_rdy1);
        end
        b_v0 = 0; b_v1 = 0; b_rr = 0;
    endtask

    task automatic test_reset_abort();
        do_reset();
        @(negedge clk);
        a_v0 = 1; a_v1 = 0; a_a0 = 8'h09; a_b0 = 8'h09; a_op0 = 2'b10;
        #1;
        n_checks++;
        if (a_rdy0 !== 1'b1) begin
            n_fail++; $display("FAIL abort_grant: got %b expected 1", a_rdy0);
        end
        @(negedge clk);
        a_v0 = 0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        a_rr  = 1;
        n_checks++;
        if (a_rv !== 1'b0 || a_alu_a !== 8'h00) begin
            n_fail++; $display("FAIL abort_state: got rv=%b alu_a=%h expected 0 00", a_rv, a_alu_a);
        end
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            n_checks++;
            if (a_rv !== 1'b0) begin
                n_fail++; $display("FAIL abort_no_rsp %0d: got rv=%b expected 0", j, a_rv);
            end
        end
        a_rr = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_v0 = 0; a_v1 = 0; a_rr = 0;
        a_a0 = 0; a_b0 = 0; a_a1 = 0; a_b1 = 0; a_op0 = 0; a_op1 = 0;
        b_v0 = 0; b_v1 = 0; b_rr = 0;
        b_a0 = 0; b_b0 = 0; b_a1 = 0; b_b1 = 0; b_op0 = 0; b_op1 = 0;
        b_alu_y = 0; b_fl_in = 0;
        test_reset();
        test_basic();
        test_round_robin();
        test_random();
        test_exec4_hold();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
